// File: rtl/sigmoid_pipe.sv
// Three-stage pipelined PLAN sigmoid with a stochastic spike output.
// A single global enable stalls the whole pipe under backpressure; bubbles are kept in place.
module sigmoid_pipe #(
  parameter int IN_W    = 12,
  parameter int IN_FRAC = 4,
  parameter int OUT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  sum,
  input  logic [OUT_W-1:0] rnd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] prob,
  output logic             spike
);
  localparam int STAGES = 3;
  localparam int F      = IN_FRAC + 5;
  localparam int YW     = F + 1;
  localparam int ZW     = IN_W + 8;

  // Segment thresholds in the input's own format; 2.375 is compared as 8*z >= 19.
  localparam logic [ZW-1:0] T_ONE  = ZW'(1)  << IN_FRAC;
  localparam logic [ZW-1:0] T_19   = ZW'(19) << IN_FRAC;
  localparam logic [ZW-1:0] T_FIVE = ZW'(5)  << IN_FRAC;

  localparam logic [YW-1:0] Y_ONE  = YW'(1)  << F;
  localparam logic [YW-1:0] C_HALF = YW'(1)  << (F - 1);
  localparam logic [YW-1:0] C_0625 = YW'(5)  << (F - 3);
  localparam logic [YW-1:0] C_0844 = YW'(27) << (F - 5);

  typedef struct packed {
    logic             sign;
    logic [IN_W-1:0]  z;
    logic [OUT_W-1:0] rnd;
  } s1_t;

  typedef struct packed {
    logic             sign;
    logic [YW-1:0]    y;
    logic [OUT_W-1:0] rnd;
  } s2_t;

  logic [STAGES:1] vld_pipe;
  logic            en;
  s1_t             s1_q, s1_d;
  s2_t             s2_q, s2_d;
  logic [ZW-1:0]   zw;
  logic [YW-1:0]   zy;
  logic [YW-1:0]   yf;
  logic [OUT_W-1:0] q_trunc;
  logic [OUT_W-1:0] prob_d;
  logic             spike_d;

  assign en        = !vld_pipe[STAGES] | out_ready;
  assign in_ready  = en;
  assign out_valid = vld_pipe[STAGES];

  // Stage 1: magnitude; the most negative input maps to 2^(IN_W-1) unsigned.
  always_comb begin
    s1_d.sign = sum[IN_W-1];
    s1_d.z    = sum[IN_W-1] ? (~sum + 1'b1) : sum;
    s1_d.rnd  = rnd;
  end

  // Stage 2: the z/32 term equals raw z once it is read with F fractional bits.
  assign zw = ZW'(s1_q.z);
  assign zy = YW'(s1_q.z);

  always_comb begin
    s2_d.sign = s1_q.sign;
    s2_d.rnd  = s1_q.rnd;
    if (zw >= T_FIVE)
      s2_d.y = Y_ONE;
    else if ((zw << 3) >= T_19)
      s2_d.y = zy + C_0844;
    else if (zw >= T_ONE)
      s2_d.y = (zy << 2) + C_0625;
    else
      s2_d.y = (zy << 3) + C_HALF;
  end

  // Stage 3: fold negatives before truncating so the result is exact.
  assign yf = s2_q.sign ? (Y_ONE - s2_q.y) : s2_q.y;

  generate
    if (F >= OUT_W) begin : g_trunc
      assign q_trunc = OUT_W'(yf[F-1:0] >> (F - OUT_W));
    end else begin : g_pad
      assign q_trunc = OUT_W'(yf[F-1:0]) << (OUT_W - F);
    end
  endgenerate

  assign prob_d  = yf[F] ? '1 : q_trunc;
  assign spike_d = s2_q.rnd < prob_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      prob     <= '0;
      spike    <= 1'b0;
    end else if (en) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      prob     <= prob_d;
      spike    <= spike_d;
    end
  end
endmodule

// File: tb/tb_sigmoid_pipe.sv
// Randomized and directed bench for sigmoid_pipe against a real-valued sigmoid approximation model.
module tb_sigmoid_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, spike;
  logic [11:0] sum;
  logic [7:0]  rnd, prob;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_spike;
  logic [15:0] b_sum;
  logic [11:0] b_rnd, b_prob;

  int checks = 0;
  int failures = 0;
  int q_sum[$];
  int q_rnd[$];
  int got_p[$];
  int got_s[$];

  sigmoid_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .sum(sum), .rnd(rnd),
    .out_valid(out_valid), .out_ready(out_ready), .prob(prob), .spike(spike)
  );

  sigmoid_pipe #(.IN_W(16), .IN_FRAC(8), .OUT_W(12)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .sum(b_sum), .rnd(b_rnd),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .prob(b_prob), .spike(b_spike)
  );

  always #5 clk = ~clk;

  // Reference: piecewise-linear sigmoid on real numbers, then floor and saturate.
  function automatic int mprob(input int s, input int infrac, input int outw);
    real x, z, y, q, full;
    x = real'(s) / real'(1 << infrac);
    z = (x < 0.0) ? -x : x;
    if (z >= 5.0)        y = 1.0;
    else if (z >= 2.375) y = z / 32.0 + 0.84375;
    else if (z >= 1.0)   y = z / 8.0 + 0.625;
    else                 y = z / 4.0 + 0.5;
    if (x < 0.0) y = 1.0 - y;
    full = real'(1 << outw);
    q = $floor(y * full);
    if (q >= full) q = full - 1.0;
    return int'(q);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives q_sum/q_rnd with optional valid gaps and output stalls; records transfers.
  task automatic stream(input int gap_pct, input int stall_pct, output bit timeout);
    int n, sent, cyc;
    bit acc;
    n = q_sum.size();
    sent = 0;
    cyc = 0;
    got_p.delete();
    got_s.delete();
    while (got_p.size() < n && cyc < 3000) begin
      if (sent < n && int'($urandom_range(99)) >= gap_pct) begin
        in_valid = 1'b1;
        sum = 12'(q_sum[sent]);
        rnd = 8'(q_rnd[sent]);
      end else begin
        in_valid = 1'b0;
      end
      out_ready = int'($urandom_range(99)) >= stall_pct;
      #1;
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        got_p.push_back(int'(prob));
        got_s.push_back(int'(spike));
      end
      @(posedge clk);
      #1;
      if (acc) sent++;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    timeout = (cyc >= 3000);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1; sum = '0; rnd = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b1; b_sum = '0; b_rnd = '0;
    #2;
    checks++;
    if (out_valid !== 1'b0 || prob !== 8'h00 || spike !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%0b p=%h s=%0b, want 0 00 0", out_valid, prob, spike);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %0b want 1", in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int vals[5] = '{0, 16, -16, 8, -8};
    int exp_p[5] = '{8'h80, 8'hC0, 8'h40, 8'hA0, 8'h60};
    bit exp_v;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_valid = (k < 5);
      if (k < 5) begin sum = 12'(vals[k]); rnd = 8'h00; end
      tick();
      exp_v = (k >= 2 && k <= 6);
      checks++;
      if (out_valid !== exp_v) begin
        failures++;
        $display("FAIL b2b_valid[%0d]: got %0b want %0b", k, out_valid, exp_v);
      end
      if (exp_v) begin
        checks++;
        if (prob !== 8'(exp_p[k-2]) || spike !== 1'b1) begin
          failures++;
          $display("FAIL b2b_data[%0d]: got p=%h s=%0b want p=%h s=1", k, prob, spike, exp_p[k-2]);
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_boundaries();
    int vals[6] = '{38, 79, 80, -80, 2047, -2048};
    int exp_p[6] = '{8'hEB, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h00};
    bit to;
    q_sum.delete(); q_rnd.delete();
    for (int i = 0; i < 6; i++) begin
      q_sum.push_back(vals[i]);
      q_rnd.push_back(int'($urandom_range(255)));
    end
    stream(0, 0, to);
    checks++;
    if (to) begin failures++; $display("FAIL bound_timeout: got %0d results want 6", got_p.size()); end
    for (int i = 0; i < got_p.size() && i < 6; i++) begin
      checks++;
      if (got_p[i] != exp_p[i] || got_s[i] != int'(q_rnd[i] < exp_p[i])) begin
        failures++;
        $display("FAIL bound[%0d] sum=%0d: got p=%h s=%0d want p=%h s=%0d",
                 i, vals[i], got_p[i], got_s[i], exp_p[i], int'(q_rnd[i] < exp_p[i]));
      end
    end
  endtask

  task automatic test_spike();
    int rs[4] = '{8'hBF, 8'hC0, 8'h00, 8'hFF};
    int exp_s[4] = '{1, 0, 1, 0};
    bit to;
    q_sum.delete(); q_rnd.delete();
    for (int i = 0; i < 4; i++) begin q_sum.push_back(16); q_rnd.push_back(rs[i]); end
    stream(0, 0, to);
    checks++;
    if (to) begin failures++; $display("FAIL spike_timeout: got %0d results want 4", got_p.size()); end
    for (int i = 0; i < got_p.size() && i < 4; i++) begin
      checks++;
      if (got_p[i] != 8'hC0 || got_s[i] != exp_s[i]) begin
        failures++;
        $display("FAIL spike[%0d] rnd=%h: got p=%h s=%0d want p=c0 s=%0d", i, rs[i], got_p[i], got_s[i], exp_s[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int vals[6];
    int rs[6];
    int sent, hold, cyc, e;
    bit acc;
    for (int i = 0; i < 6; i++) begin
      vals[i] = int'($urandom_range(4095)) - 2048;
      rs[i] = int'($urandom_range(255));
    end
    sent = 0; hold = 0; cyc = 0;
    got_p.delete(); got_s.delete();
    while (got_p.size() < 6 && cyc < 200) begin
      in_valid = (sent < 6);
      if (sent < 6) begin sum = 12'(vals[sent]); rnd = 8'(rs[sent]); end
      out_ready = !(out_valid && hold < 4);
      #1;
      if (!out_ready) begin
        checks++;
        if (in_ready !== 1'b0 || prob !== 8'(mprob(vals[0], 4, 8))) begin
          failures++;
          $display("FAIL bp_hold[%0d]: got in_ready=%0b p=%h want 0 p=%h", hold, in_ready, prob, mprob(vals[0], 4, 8));
        end
        hold++;
      end
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin got_p.push_back(int'(prob)); got_s.push_back(int'(spike)); end
      tick();
      if (acc) sent++;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (got_p.size() != 6 || hold != 4) begin
      failures++;
      $display("FAIL bp_count: got %0d results hold=%0d want 6 hold=4", got_p.size(), hold);
    end
    for (int i = 0; i < got_p.size() && i < 6; i++) begin
      e = mprob(vals[i], 4, 8);
      checks++;
      if (got_p[i] != e || got_s[i] != int'(rs[i] < e)) begin
        failures++;
        $display("FAIL bp_data[%0d] sum=%0d: got p=%h s=%0d want p=%h s=%0d", i, vals[i], got_p[i], got_s[i], e, int'(rs[i] < e));
      end
    end
  endtask

  task automatic test_random_gaps();
    int bad, e;
    bit to;
    q_sum.delete(); q_rnd.delete();
    for (int i = 0; i < 60; i++) begin
      q_sum.push_back(int'($urandom_range(4095)) - 2048);
      q_rnd.push_back(int'($urandom_range(255)));
    end
    for (int i = 0; i < 10; i++) q_sum[i] = int'($urandom_range(200)) - 100;
    stream(35, 30, to);
    checks++;
    if (to || got_p.size() != 60) begin
      failures++;
      $display("FAIL rand_count: got %0d results want 60", got_p.size());
    end
    bad = 0;
    for (int i = 0; i < got_p.size() && i < 60; i++) begin
      e = mprob(q_sum[i], 4, 8);
      checks++;
      if (got_p[i] != e || got_s[i] != int'(q_rnd[i] < e)) begin
        failures++;
        if (bad < 5) $display("FAIL rand[%0d] sum=%0d rnd=%h: got p=%h s=%0d want p=%h s=%0d",
                              i, q_sum[i], q_rnd[i], got_p[i], got_s[i], e, int'(q_rnd[i] < e));
        bad++;
      end
    end
  endtask

  task automatic test_midreset();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; sum = 12'd16; rnd = 8'h00;
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || prob !== 8'hC0) begin
      failures++;
      $display("FAIL mr_inflight: got v=%0b p=%h want 1 c0", out_valid, prob);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || prob !== 8'h00 || spike !== 1'b0) begin
      failures++;
      $display("FAIL mr_async_clear: got v=%0b p=%h s=%0b want 0 00 0", out_valid, prob, spike);
    end
    #3 rst = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL mr_stale[%0d]: got v=%0b want 0", k, out_valid);
      end
      tick();
    end
    in_valid = 1'b1; sum = 12'd0; rnd = 8'h00;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL mr_early[%0d]: got v=%0b want 0", k, out_valid);
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b1 || prob !== 8'h80) begin
      failures++;
      $display("FAIL mr_after: got v=%0b p=%h want 1 80", out_valid, prob);
    end
    tick();
  endtask

  task automatic test_params();
    int vals[8];
    int rs[8];
    int exp_p[8];
    int got[$];
    int e;
    vals[0] = 0; vals[1] = 256; vals[2] = -1280;
    exp_p[0] = 12'h800; exp_p[1] = 12'hC00; exp_p[2] = 12'h000;
    for (int i = 0; i < 8; i++) rs[i] = int'($urandom_range(4095));
    for (int i = 3; i < 8; i++) begin
      vals[i] = int'($urandom_range(65535)) - 32768;
      if (i < 6) vals[i] = int'($urandom_range(2800)) - 1400;
      exp_p[i] = mprob(vals[i], 8, 12);
    end
    b_out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      b_in_valid = (k < 8);
      if (k < 8) begin b_sum = 16'(vals[k]); b_rnd = 12'(rs[k]); end
      tick();
      if (b_out_valid) begin
        got.push_back(int'(b_prob));
        e = got.size() - 1;
        checks++;
        if (e >= 8 || int'(b_prob) != exp_p[e] || int'(b_spike) != int'(rs[e] < exp_p[e])) begin
          failures++;
          $display("FAIL param[%0d]: got p=%h s=%0b want p=%h", e, b_prob, b_spike, (e < 8) ? exp_p[e] : -1);
        end
      end
    end
    b_in_valid = 1'b0;
    checks++;
    if (got.size() != 8) begin
      failures++;
      $display("FAIL param_count: got %0d want 8", got.size());
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_boundaries();
    test_spike();
    test_backpressure();
    test_random_gaps();
    test_midreset();
    test_params();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sigmoid_pipe.md
# sigmoid_pipe

Pipelined, parametrised successor to the combinational sigmoid unit. It maps a signed fixed-point neuron pre-activation sum to a PLAN-approximated sigmoid probability. It also emits a stochastic spike by comparing that probability against a uniform random word. It sits between the matrix-multiply accumulator and the RBM sampling/iteration loop, and uses a valid/ready handshake on both sides with full backpressure.

## Interface
- IN_W, 12, input sum width, two's complement
- IN_FRAC, 4, fractional bits of input (Q(IN_W-IN_FRAC).IN_FRAC); IN_W-IN_FRAC >= 4 required
- OUT_W, 8, output probability width, unsigned Q0.OUT_W, no sign bit
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  sum/rnd valid
- in_ready  out  1  unit accepts when in_valid & in_ready
- sum  in  IN_W  signed pre-activation
- rnd  in  OUT_W  uniform random word, sampled with sum
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts when out_valid & out_ready
- prob  out  OUT_W  sigmoid(sum), Q0.OUT_W
- spike  out  1  1 iff rnd < prob (unsigned compare)

## Operation
- Stage 1 (capture):
  - sign = sum[IN_W-1].
  - z = |sum| as IN_W-bit unsigned; -2^(IN_W-1) gives z = 2^(IN_W-1), no overflow.
  - rnd is registered alongside.
- Stage 2 (PLAN), computed on z exactly with F = IN_FRAC+5 fractional bits, thresholds compared in IN_FRAC format:
  - z >= 5.0: y = 1.0
  - 2.375 <= z < 5.0: y = z/32 + 0.84375
  - 1.0 <= z < 2.375: y = z/8 + 0.625
  - z < 1.0: y = z/4 + 0.5
- Stage 3 (fold/quantise):
  - If sign = 1, y = 1.0 - y (exact, F bits).
  - Truncate (floor) to OUT_W fractional bits; zero-pad if F < OUT_W.
  - Any y >= 1.0 saturates to 2^OUT_W - 1.
  - spike = (rnd_s3 < prob_value).
- Exact arithmetic: shifts only, no multipliers, no rounding before the final truncation.
- Input 0 produces exactly 0.5; the negative fold is applied before truncation.

## Timing
- Three register stages, each with its own valid bit v1..v3.
- Global advance enable: en = !v3 | out_ready.
- Handshake:
  - in_ready = en, a combinational path from out_ready.
  - All stages shift when en = 1; all hold when en = 0.
  - Bubbles are not collapsed.
- Latency: 3 cycles, accept edge to out_valid, with no stall. Throughput is 1 result/cycle while out_ready = 1.
- out_valid = v3.
- prob/spike stay stable while out_valid & !out_ready.
- in_valid = 0 on an enabled edge inserts a bubble; it does not drop stages.
- Reset, asynchronous:
  - v1..v3 = 0; all data registers = 0.
  - out_valid = 0, prob = 0, spike = 0.
  - in_ready = 1 while rst is deasserted, since en = 1 with v3 = 0.
- Reset mid-stream: all in-flight results are discarded; none appear after release.
- in_ready is 1 whenever out_ready = 1, so a simultaneous accept and output transfer is legal.

## Test plan
- Defaults, no stall. Send sum = 0, 16 (1.0), -16, 8 (0.5), -8 back-to-back; all with rnd = 0.
  - Required prob sequence: 0x80, 0xC0, 0x40, 0xA0, 0x60.
  - Required spike sequence: 1 each.
  - out_valid rises exactly 3 cycles after the first accept; results come on consecutive cycles.
- Segment boundaries:
  - sum = 38 (2.375) -> 0xEB.
  - sum = 79 (4.9375) -> 0xFF.
  - sum = 80 (5.0) -> 0xFF.
  - sum = -80 -> 0x00.
  - sum = 2047 -> 0xFF.
  - sum = -2048 -> 0x00, with no wrap.
- Stochastic compare, sum = 16 (prob 0xC0):
  - rnd = 0xBF -> spike 1.
  - rnd = 0xC0 -> spike 0.
  - rnd = 0x00 -> spike 1.
  - rnd = 0xFF -> spike 0.
- Backpressure:
  - Stream 6 inputs; hold out_ready = 0 for 4 cycles once out_valid = 1.
  - in_ready must be 0 during the hold, and prob must be held constant.
  - All 6 results must arrive in order with none lost or duplicated.
  - Also stream with random in_valid gaps: results must stay in order.
- Reset mid-stream:
  - Assert rst asynchronously (off clock edge) with 3 results in flight.
  - out_valid, prob and spike must go to 0 immediately.
  - After release, no stale output appears; the next input (sum = 0) yields 0x80 after 3 cycles.
- Parameter sweep with IN_W = 16, IN_FRAC = 8, OUT_W = 12:
  - sum = 0 -> 0x800.
  - sum = 256 (1.0) -> 0xC00.
  - sum = -1280 (-5.0) -> 0x000.
